mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage.sv | 108 ++++++++++
 tb/tb_mem_stage.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// mem_stage: memory pipeline stage that passes ALU results through or runs one blocking load/store
// with a 256-cycle watchdog that aborts a request the memory never acknowledges.
module mem_stage (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_exe_mem,
    input  logic [127:0] i_result,
    input  logic [63:0]  i_rflags,
    input  logic [1:0]   i_mem_op,
    input  logic [1:0]   i_mem_size,
    input  logic [63:0]  i_mem_addr,
    input  logic [3:0]   i_dst_reg,
    output logic         o_mem_blocked,
    output logic         o_mem_req,
    output logic         o_mem_we,
    output logic [63:0]  o_mem_req_addr,
    output logic [63:0]  o_mem_wdata,
    output logic [1:0]   o_mem_req_size,
    input  logic         i_mem_ack,
    input  logic [63:0]  i_mem_rdata,
    output logic         o_wb_valid,
    output logic         o_wb_reg_en,
    output logic [3:0]   o_wb_reg,
    output logic [63:0]  o_wb_data,
    output logic [63:0]  o_wb_hi,
    output logic [63:0]  o_wb_rflags,
    output logic         o_mem_err
);
    typedef enum logic {IDLE, REQ} state_t;
    state_t      r_state;
    logic [7:0]  r_wdog;
    logic [3:0]  r_dst;
    logic [63:0] r_flags;
    logic        w_is_mem;
    logic [63:0] w_in_mask;
    logic [63:0] w_req_mask;

    function automatic logic [63:0] size_mask(input logic [1:0] s);
        return s == 2'd0 ? 64'hFF : s == 2'd1 ? 64'hFFFF : s == 2'd2 ? 64'hFFFF_FFFF : '1;
    endfunction

    always_comb begin
        w_is_mem   = i_mem_op == 2'd1 || i_mem_op == 2'd2;
        w_in_mask  = size_mask(i_mem_size);
        w_req_mask = size_mask(o_mem_req_size);
    end

    // Backpressure and request valid come straight from the state register.
    assign o_mem_blocked = r_state == REQ;
    assign o_mem_req     = r_state == REQ;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state        <= IDLE;
            r_wdog         <= '0;
            r_dst          <= '0;
            r_flags        <= '0;
            o_mem_we       <= 1'b0;
            o_mem_req_addr <= '0;
            o_mem_wdata    <= '0;
            o_mem_req_size <= '0;
            o_wb_valid     <= 1'b0;
            o_wb_reg_en    <= 1'b0;
            o_wb_reg       <= '0;
            o_wb_data      <= '0;
            o_wb_hi        <= '0;
            o_wb_rflags    <= '0;
            o_mem_err      <= 1'b0;
        end else begin
            o_wb_valid  <= 1'b0;
            o_wb_reg_en <= 1'b0;
            o_mem_err   <= 1'b0;
            if (r_state == IDLE) begin
                if (i_exe_mem && w_is_mem) begin
                    r_state        <= REQ;
                    r_wdog         <= '0;
                    r_dst          <= i_dst_reg;
                    r_flags        <= i_rflags;
                    o_mem_we       <= i_mem_op == 2'd2;
                    o_mem_req_addr <= i_mem_addr;
                    o_mem_wdata    <= i_result[63:0] & w_in_mask;
                    o_mem_req_size <= i_mem_size;
                end else if (i_exe_mem) begin
                    o_wb_valid  <= 1'b1;
                    o_wb_reg_en <= 1'b1;
                    o_wb_reg    <= i_dst_reg;
                    o_wb_data   <= i_result[63:0];
                    o_wb_hi     <= i_result[127:64];
                    o_wb_rflags <= i_rflags;
                end
            end else if (i_mem_ack) begin
                r_state     <= IDLE;
                o_wb_valid  <= 1'b1;
                o_wb_reg_en <= ~o_mem_we;
                o_wb_reg    <= r_dst;
                o_wb_data   <= o_mem_we ? 64'd0 : i_mem_rdata & w_req_mask;
                o_wb_hi     <= '0;
                o_wb_rflags <= r_flags;
            end else if (r_wdog == 8'hFF) begin
                r_state    <= IDLE;
                o_wb_valid <= 1'b1;
                o_mem_err  <= 1'b1;
            end else begin
                r_wdog <= r_wdog + 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: random and directed transactions against a transaction-level model of the memory stage.
module tb_mem_stage;
    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         exe_mem = 1'b0;
    logic [127:0] result = '0;
    logic [63:0]  rflags = '0;
    logic [1:0]   mem_op = '0;
    logic [1:0]   mem_size = '0;
    logic [63:0]  mem_addr = '0;
    logic [3:0]   dst_reg = '0;
    logic         mem_ack = 1'b0;
    logic [63:0]  mem_rdata = '0;
    logic         mem_blocked, mem_req, mem_we, wb_valid, wb_reg_en, mem_err;
    logic [63:0]  mem_req_addr, mem_wdata, wb_data, wb_hi, wb_rflags;
    logic [1:0]   mem_req_size;
    logic [3:0]   wb_reg;
    int           n_run = 0;
    int           n_fail = 0;
    bit           hold = 1'b0;
    logic [127:0] h_res;
    logic [63:0]  h_flags;
    logic [3:0]   h_dst;

    mem_stage dut (
        .i_clk(clk), .i_reset(reset), .i_exe_mem(exe_mem), .i_result(result), .i_rflags(rflags),
        .i_mem_op(mem_op), .i_mem_size(mem_size), .i_mem_addr(mem_addr), .i_dst_reg(dst_reg),
        .o_mem_blocked(mem_blocked), .o_mem_req(mem_req), .o_mem_we(mem_we),
        .o_mem_req_addr(mem_req_addr), .o_mem_wdata(mem_wdata), .o_mem_req_size(mem_req_size),
        .i_mem_ack(mem_ack), .i_mem_rdata(mem_rdata), .o_wb_valid(wb_valid),
        .o_wb_reg_en(wb_reg_en), .o_wb_reg(wb_reg), .o_wb_data(wb_data), .o_wb_hi(wb_hi),
        .o_wb_rflags(wb_rflags), .o_mem_err(mem_err)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "simulation time limit");
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] zext(input logic [63:0] v, input logic [1:0] s);
        int nbytes = 1 << s;
        return s == 2'd3 ? v : v & ((64'd1 << (8 * nbytes)) - 64'd1);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_checks(input string tag);
        chk({tag, "_wbv"}, wb_valid, 0);
        chk({tag, "_regen"}, wb_reg_en, 0);
        chk({tag, "_err"}, mem_err, 0);
    endtask

    task automatic req_checks(input logic [1:0] op, input logic [1:0] sz, input logic [63:0] addr,
                              input logic [63:0] res);
        chk("req", mem_req, 1);
        chk("blocked", mem_blocked, 1);
        chk("we", mem_we, op == 2'd2);
        chk("req_addr", mem_req_addr, addr);
        chk("req_size", mem_req_size, sz);
        chk("wdata", mem_wdata, zext(res, sz));
        idle_checks("in_req");
    endtask

    // d = cycles of REQ before the ack cycle; d >= 256 means the memory never answers.
    task automatic issue(input logic [1:0] op, input logic [1:0] sz, input logic [63:0] addr,
                         input logic [127:0] res, input logic [63:0] fl, input logic [3:0] dst,
                         input int d, input logic [63:0] rd);
        bit is_mem = op == 2'd1 || op == 2'd2;
        exe_mem = 1'b1; mem_op = op; mem_size = sz; mem_addr = addr;
        result = res; rflags = fl; dst_reg = dst;
        mem_ack = is_mem ? 1'b0 : 1'($urandom % 2);
        mem_rdata = {$urandom, $urandom};
        tick();
        mem_ack = 1'b0;
        if (!is_mem) begin
            exe_mem = 1'b0;
            chk("alu_wbv", wb_valid, 1);
            chk("alu_regen", wb_reg_en, 1);
            chk("alu_data", wb_data, res[63:0]);
            chk("alu_hi", wb_hi, res[127:64]);
            chk("alu_reg", wb_reg, dst);
            chk("alu_flags", wb_rflags, fl);
            chk("alu_err", mem_err, 0);
            chk("alu_blocked", mem_blocked, 0);
            return;
        end
        if (hold) begin
            exe_mem = 1'b1; mem_op = 2'd0; result = h_res; rflags = h_flags; dst_reg = h_dst;
        end else begin
            exe_mem = 1'($urandom % 2); mem_op = 2'($urandom); result = {4{$urandom}};
        end
        req_checks(op, sz, addr, res[63:0]);
        for (int c = 0; c < (d >= 256 ? 255 : d); c++) begin
            tick();
            req_checks(op, sz, addr, res[63:0]);
        end
        if (d < 256) begin
            mem_ack = 1'b1; mem_rdata = rd;
        end
        tick();
        mem_ack = 1'b0;
        if (!hold) exe_mem = 1'b0;
        chk("done_wbv", wb_valid, 1);
        chk("done_req", mem_req, 0);
        chk("done_blocked", mem_blocked, 0);
        if (d >= 256) begin
            chk("to_err", mem_err, 1);
            chk("to_regen", wb_reg_en, 0);
        end else begin
            chk("done_err", mem_err, 0);
            chk("done_regen", wb_reg_en, op == 2'd1);
            chk("done_data", wb_data, op == 2'd1 ? zext(rd, sz) : 64'd0);
            chk("done_hi", wb_hi, 0);
            chk("done_reg_flags", {wb_reg, wb_rflags}, {dst, fl});
        end
    endtask

    initial begin
        tick(); tick();
        reset = 1'b0;
        chk("rst_outs", {mem_blocked, mem_req, mem_we, wb_valid, wb_reg_en, mem_err}, 0);
        chk("rst_data", {mem_req_addr, mem_wdata, wb_data}, 0);
        chk("rst_wb", {wb_hi, wb_rflags, wb_reg, mem_req_size}, 0);
        tick();
        idle_checks("idle0");
        // Three back-to-back ALU results.
        for (int i = 1; i <= 3; i++) issue(2'd0, 2'd0, 0, 128'(i), 64'h5, 4'(i), 0, 0);
        tick();
        idle_checks("after_alu");
        issue(2'd1, 2'd0, 64'h1000, 0, 64'hA5, 4'd7, 2, 64'hDEADBEEFCAFEF00D);
        chk("load_byte", wb_data, 64'h0D);
        issue(2'd2, 2'd2, 64'h2000, 128'h1122334455667788, 64'h3, 4'd2, 0, 0);
        chk("store_wdata", mem_wdata, 64'h55667788);
        issue(2'd1, 2'd3, 64'h3000, 0, 64'h1, 4'd1, 256, 0);
        tick();
        idle_checks("after_timeout");
        chk("after_timeout_req", mem_req, 0);
        issue(2'd1, 2'd1, 64'h4000, 0, 64'h2, 4'd3, 255, 64'h123456789ABCDEF0);
        // Reset during the second REQ cycle, then a late ack.
        exe_mem = 1'b1; mem_op = 2'd1; mem_size = 2'd3; mem_addr = 64'h5000; dst_reg = 4'd9;
        tick();
        exe_mem = 1'b0;
        tick();
        chk("rm_req2", mem_req, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rm_outs", {mem_req, mem_blocked, wb_valid, mem_err}, 0);
        mem_ack = 1'b1; mem_rdata = 64'hFFFF;
        tick();
        mem_ack = 1'b0;
        chk("rm_late_ack", {mem_req, mem_blocked, wb_valid, wb_reg_en, mem_err}, 0);
        tick();
        idle_checks("rm_after");
        // Load with an ALU op held during REQ: that op retires exactly once, right after the load.
        hold = 1'b1; h_res = {64'hAB, 64'hCD}; h_flags = 64'h77; h_dst = 4'd4;
        issue(2'd1, 2'd2, 64'h6000, 0, 64'h8, 4'd5, 3, 64'hFFEEDDCCBBAA9988);
        hold = 1'b0;
        issue(2'd0, 2'd0, 0, h_res, h_flags, h_dst, 0, 0);
        tick();
        idle_checks("held_once");
        for (int n = 0; n < 80; n++) begin
            logic [1:0] op = 2'($urandom);
            int d = ($urandom % 25 == 0) ? 255 : int'($urandom_range(0, 6));
            issue(op, 2'($urandom), {$urandom, $urandom}, {4{$urandom}}, {$urandom, $urandom},
                  4'($urandom), d, {$urandom, $urandom});
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
                tick();
                idle_checks("gap");
            end
        end
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
